uart16550_rxfifo: RTL and testbench



---
 rtl/uart16550_pkg.sv | 30 +++
 rtl/uart16550_rx_timeout.sv | 40 ++++
 rtl/uart16550_rxfifo.sv | 146 ++++++++++++++
 tb/tb_uart16550_rxfifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart16550_pkg.sv
// Shared types for the 16550 receive path: per-character record and trigger-level code.
package uart16550_pkg;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bi;
  } rx_d_t;

  typedef enum logic [1:0] {
    rtl_1  = 2'b00,
    rtl_4  = 2'b01,
    rtl_8  = 2'b10,
    rtl_14 = 2'b11
  } rcvr_trig_e;

  function automatic logic [4:0] trig_level(input rcvr_trig_e t);
    logic [4:0] lvl;
    unique case (t)
      rtl_1:   lvl = 5'd1;
      rtl_4:   lvl = 5'd4;
      rtl_8:   lvl = 5'd8;
      rtl_14:  lvl = 5'd14;
      default: lvl = 5'd1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart16550_rx_timeout.sv
// Character-timeout counter: reloads on FIFO activity, counts baud ticks down while data waits.
module uart16550_rx_timeout (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic [9:0] load_i,
  input  logic       reload_i,
  input  logic       active_i,
  input  logic       dr_next_i,
  input  logic       fifo_en_i,
  output logic       timeout_o
);

  logic [9:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = load_i;
    end else if (tick_i && active_i && (cnt_q != 10'd0)) begin
      cnt_d = cnt_q - 10'd1;
    end
    // Flag follows next-state so it clears the cycle after a push or pop.
    timeout_d = (cnt_d == 10'd0) && dr_next_i && fifo_en_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= 10'h3FF;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/uart16550_rxfifo.sv
// 16550 receive FIFO / 16450 RBR with trigger, overrun, error-in-FIFO and character timeout.
// The timeout counter is built only when UART16550_RXFIFO_TIMEOUT_EN is defined.
module uart16550_rxfifo
  import uart16550_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     baudout_i,
  input  logic                     fifo_en_i,
  input  logic [1:0]               rtl_i,
  input  logic                     flush_i,
  input  logic [9:0]               timeout_load_i,
  input  logic                     push_i,
  input  rx_d_t                    d_i,
  input  logic                     pop_i,
  input  logic                     clr_oe_i,
  output rx_d_t                    q_o,
  output logic                     dr_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     trigger_o,
  output logic                     timeout_o,
  output logic                     oe_o,
  output logic                     err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rx_d_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d, err_cnt_q, err_cnt_d;
  logic [CW-1:0] eff_depth, level;
  logic          fen_q, fen_flush_q;
  logic          dr_q, full_q, oe_q, err_q, trig_q;
  logic          dr_d, full_d, oe_d, err_d, trig_d;
  logic          flush, pop_ok, push_ok, overrun;
  logic          head_err, d_err;
  rx_d_t         head;

  assign flush    = flush_i | fen_flush_q;
  assign head     = mem_q[rd_ptr_q];
  assign head_err = head.pe | head.fe | head.bi;
  assign d_err    = d_i.pe | d_i.fe | d_i.bi;

  // Flush wins over both strobes; a pop on an empty FIFO is dropped.
  assign pop_ok   = pop_i & (cnt_q != '0) & ~flush;
  assign push_ok  = push_i & (~full_q | pop_ok) & ~flush;
  assign overrun  = push_i & full_q & ~pop_ok & ~flush;

  assign eff_depth = fifo_en_i ? CW'(DEPTH) : CW'(1);
  assign level     = CW'(trig_level(rcvr_trig_e'(rtl_i)));

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      err_cnt_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d     = cnt_q + CW'(push_ok) - CW'(pop_ok);
      err_cnt_d = err_cnt_q + CW'(push_ok & d_err) - CW'(pop_ok & head_err);
    end
    dr_d   = (cnt_d != '0);
    full_d = (cnt_d >= eff_depth);
    trig_d = fifo_en_i ? (cnt_d >= level) : dr_d;
    err_d  = fifo_en_i & (err_cnt_d != '0);
    oe_d   = overrun ? 1'b1 : (clr_oe_i ? 1'b0 : oe_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_cnt_q   <= '0;
      fen_q       <= 1'b0;
      fen_flush_q <= 1'b0;
      dr_q        <= 1'b0;
      full_q      <= 1'b0;
      trig_q      <= 1'b0;
      err_q       <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
      fen_q       <= fifo_en_i;
      fen_flush_q <= (fifo_en_i != fen_q);
      dr_q        <= dr_d;
      full_q      <= full_d;
      trig_q      <= trig_d;
      err_q       <= err_d;
      oe_q        <= oe_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= d_i;
    end
  end

  // Stale storage flags must not leak out while empty.
  always_comb begin
    q_o    = head;
    q_o.pe = head.pe & dr_q;
    q_o.fe = head.fe & dr_q;
    q_o.bi = head.bi & dr_q;
  end

  assign dr_o      = dr_q;
  assign full_o    = full_q;
  assign count_o   = cnt_q;
  assign trigger_o = trig_q;
  assign oe_o      = oe_q;
  assign err_o     = err_q;

`ifdef UART16550_RXFIFO_TIMEOUT_EN
  uart16550_rx_timeout u_rx_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tick_i    (baudout_i),
    .load_i    (timeout_load_i),
    .reload_i  (flush | push_ok | pop_ok),
    .active_i  (cnt_q != '0),
    .dr_next_i (dr_d),
    .fifo_en_i (fifo_en_i),
    .timeout_o (timeout_o)
  );
`else
  logic unused_timeout;
  assign unused_timeout = baudout_i ^ (^timeout_load_i);
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart16550_rxfifo.sv
// Scoreboard bench for uart16550_rxfifo: expected characters queued on push, compared on pop.
module tb_uart16550_rxfifo;
  import uart16550_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i, baudout_i, fifo_en_i, flush_i, push_i, pop_i, clr_oe_i;
  logic [1:0] rtl_i;
  logic [9:0] timeout_load_i;
  rx_d_t      d_i, q_o;
  logic       dr_o, full_o, trigger_o, timeout_o, oe_o, err_o;
  logic [4:0] count_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  sb [$];
  logic        exp_tmo;

  always #5 clk = ~clk;

  uart16550_rxfifo #(.DEPTH(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .baudout_i      (baudout_i),
    .fifo_en_i      (fifo_en_i),
    .rtl_i          (rtl_i),
    .flush_i        (flush_i),
    .timeout_load_i (timeout_load_i),
    .push_i         (push_i),
    .d_i            (d_i),
    .pop_i          (pop_i),
    .clr_oe_i       (clr_oe_i),
    .q_o            (q_o),
    .dr_o           (dr_o),
    .full_o         (full_o),
    .count_o        (count_o),
    .trigger_o      (trigger_o),
    .timeout_o      (timeout_o),
    .oe_o           (oe_o),
    .err_o          (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] b, input logic fe_b, input logic accept);
    push_i = 1'b1;
    d_i    = '{d: b, pe: 1'b0, fe: fe_b, bi: 1'b0};
    step();
    push_i = 1'b0;
    if (accept) sb.push_back(b);
  endtask

  task automatic do_pop();
    logic [7:0] e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("head", {24'd0, q_o.d}, {24'd0, e});
    end
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
  endtask

  task automatic tick();
    baudout_i = 1'b1;
    step();
    baudout_i = 1'b0;
    step();
  endtask

  initial begin
`ifdef UART16550_RXFIFO_TIMEOUT_EN
    exp_tmo = 1'b1;
`else
    exp_tmo = 1'b0;
`endif
    rst_i = 1'b1; baudout_i = 1'b0; fifo_en_i = 1'b1; flush_i = 1'b0; push_i = 1'b0;
    pop_i = 1'b0; clr_oe_i = 1'b0; rtl_i = 2'b01; timeout_load_i = 10'd64;
    d_i = '0;
    step(); step();
    check("rst_dr", dr_o, 0);
    check("rst_full", full_o, 0);
    check("rst_count", count_o, 0);
    check("rst_trig", trigger_o, 0);
    check("rst_tmo", timeout_o, 0);
    check("rst_oe", oe_o, 0);
    check("rst_err", err_o, 0);
    check("rst_qflags", {q_o.pe, q_o.fe, q_o.bi}, 0);
    rst_i = 1'b0;
    repeat (3) step();

    // Trigger level 4.
    for (int i = 0; i < 4; i++) begin
      do_push(8'h41 + 8'(i), 1'b0, 1'b1);
      if (i == 2) check("trig_at3", trigger_o, 0);
    end
    check("trig_at4", trigger_o, 1);
    check("count4", count_o, 4);
    do_pop();
    check("head_after_pop", {24'd0, q_o.d}, {24'd0, sb[0]});
    check("trig_fall", trigger_o, 0);
    while (sb.size() != 0) do_pop();
    check("empty_dr", dr_o, 0);

    // Fill, overrun, clear, push+pop while full.
    for (int i = 0; i < 16; i++) do_push(8'h80 + 8'(i), 1'b0, 1'b1);
    check("full", full_o, 1);
    check("count16", count_o, 16);
    check("no_oe_yet", oe_o, 0);
    do_push(8'h99, 1'b0, 1'b0);
    check("oe_set", oe_o, 1);
    check("count_ovr", count_o, 16);
    clr_oe_i = 1'b1; step(); clr_oe_i = 1'b0;
    check("oe_clr", oe_o, 0);
    push_i = 1'b1; d_i = '{d: 8'hA0, pe: 1'b0, fe: 1'b0, bi: 1'b0};
    do_pop();
    push_i = 1'b0; sb.push_back(8'hA0);
    check("pp_full_oe", oe_o, 0);
    check("pp_full_cnt", count_o, 16);
    while (sb.size() != 0) do_pop();
    check("drained", count_o, 0);

    // Error in FIFO.
    do_push(8'h10, 1'b1, 1'b1);
    do_push(8'h20, 1'b0, 1'b1);
    check("err_set", err_o, 1);
    check("head_fe", q_o.fe, 1);
    do_pop();
    check("err_clr", err_o, 0);
    do_pop();

    // Character timeout.
    do_push(8'h33, 1'b0, 1'b1);
    repeat (63) tick();
    check("tmo_63", timeout_o, 0);
    tick();
    check("tmo_64", timeout_o, exp_tmo);
    do_pop();
    check("tmo_pop", timeout_o, 0);

    // 16450 mode.
    fifo_en_i = 1'b0;
    repeat (3) step();
    do_push(8'h55, 1'b0, 1'b1);
    check("m50_full", full_o, 1);
    check("m50_trig", trigger_o, 1);
    check("m50_cnt", count_o, 1);
    do_push(8'h66, 1'b0, 1'b0);
    check("m50_oe", oe_o, 1);
    check("m50_head", {24'd0, q_o.d}, {24'd0, sb[0]});
    fifo_en_i = 1'b1;
    repeat (3) step();
    check("toggle_cnt", count_o, 0);
    check("toggle_dr", dr_o, 0);
    sb.delete();
    clr_oe_i = 1'b1; step(); clr_oe_i = 1'b0;

    // Mid-stream reset.
    for (int i = 0; i < 3; i++) do_push(8'hC0 + 8'(i), 1'b1, 1'b1);
    check("pre_rst_cnt", count_o, 3);
    rst_i = 1'b1;
    #1;
    check("arst_cnt", count_o, 0);
    check("arst_dr", dr_o, 0);
    check("arst_err", err_o, 0);
    check("arst_qflags", {q_o.pe, q_o.fe, q_o.bi}, 0);
    step();
    rst_i = 1'b0;
    sb.delete();
    repeat (3) step();

    // Flush beats a simultaneous push.
    do_push(8'h70, 1'b0, 1'b1);
    flush_i = 1'b1;
    do_push(8'h77, 1'b0, 1'b0);
    flush_i = 1'b0;
    check("flush_cnt", count_o, 0);
    check("flush_dr", dr_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
